// File: rtl/clac_rr_sched.sv
// Round-robin scheduler sharing one combinational clac between two requesters.
// One command in flight: IDLE accepts, EXEC holds ctrl for CLAC_LAT cycles, RESP returns result.
module clac_rr_sched #(
  parameter int CLAC_LAT = 1,
  parameter int DW       = 16
) (
  input  logic            hclk,
  input  logic            hresetn,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [1:0]      req0_mode,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [2*DW-1:0] rsp0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [1:0]      req1_mode,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [2*DW-1:0] rsp1_data,
  output logic            ctrl,
  output logic [1:0]      clac_mode,
  output logic [DW-1:0]   opcode_a,
  output logic [DW-1:0]   opcode_b,
  input  logic [2*DW-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAT_INIT = 4'(CLAC_LAT - 1);

  state_t     state;
  logic       last_grant;
  logic       owner;
  logic       grant;
  logic       accept;
  logic [3:0] lat_cnt;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant;
  end

  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = hresetn && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = hresetn && (state == IDLE) && req1_valid &&  grant;
  assign busy       = (state != IDLE);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      lat_cnt    <= '0;
      ctrl       <= 1'b0;
      clac_mode  <= '0;
      opcode_a   <= '0;
      opcode_b   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            clac_mode  <= grant ? req1_mode : req0_mode;
            opcode_a   <= grant ? req1_a    : req0_a;
            opcode_b   <= grant ? req1_b    : req0_b;
            owner      <= grant;
            last_grant <= grant;
            ctrl       <= 1'b1;
            lat_cnt    <= LAT_INIT;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (lat_cnt == 4'd0) begin
            ctrl  <= 1'b0;
            state <= RESP;
            if (owner) begin
              rsp1_valid <= 1'b1;
              rsp1_data  <= result;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_data  <= result;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP: begin
          // Data registers keep the result after the handshake.
          if (owner ? rsp1_ready : rsp0_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clac_rr_sched.sv
// Bench for clac_rr_sched: transaction-level model checked every cycle on a CLAC_LAT=1
// instance, plus directed literal checks including a CLAC_LAT=4 instance.
module tb_clac_rr_sched;
  localparam int DW = 16;
  localparam int RW = 2 * DW;
  localparam int LAT = 1;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [1:0]    req0_mode, req1_mode, clac_mode;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b, opcode_a, opcode_b;
  logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [RW-1:0] rsp0_data, rsp1_data, result;
  logic          ctrl, busy;

  logic          q0_valid, q0_ready, q1_ready, s0_valid, s1_valid, s0_ready, ctrl4, busy4;
  logic [1:0]    mode4;
  logic [DW-1:0] q0_a, q0_b, opa4, opb4;
  logic [RW-1:0] s0_data, s1_data, result4;

  int total = 0;
  int bad = 0;

  function automatic logic [RW-1:0] clac_fn(input logic [1:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (m)
      2'd0:    return RW'(a) + RW'(b);
      2'd1:    return RW'(a) - RW'(b);
      2'd2:    return RW'(a) * RW'(b);
      default: return {a, b};
    endcase
  endfunction

  // Stand-in for the clac on the main instance.
  assign result = clac_fn(clac_mode, opcode_a, opcode_b);

  clac_rr_sched #(.CLAC_LAT(LAT), .DW(DW)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .ctrl(ctrl), .clac_mode(clac_mode), .opcode_a(opcode_a), .opcode_b(opcode_b),
    .result(result), .busy(busy)
  );

  clac_rr_sched #(.CLAC_LAT(4), .DW(DW)) dut4 (
    .hclk(hclk), .hresetn(hresetn),
    .req0_valid(q0_valid), .req0_ready(q0_ready), .req0_mode(2'd0), .req0_a(q0_a), .req0_b(q0_b),
    .rsp0_valid(s0_valid), .rsp0_ready(s0_ready), .rsp0_data(s0_data),
    .req1_valid(1'b0), .req1_ready(q1_ready), .req1_mode(2'd0), .req1_a('0), .req1_b('0),
    .rsp1_valid(s1_valid), .rsp1_ready(1'b1), .rsp1_data(s1_data),
    .ctrl(ctrl4), .clac_mode(mode4), .opcode_a(opa4), .opcode_b(opb4),
    .result(result4), .busy(busy4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one job at a time, ctrl for LAT cycles, then a pending response.
  bit            m_act = 0, m_owner = 0, m_last = 1;
  int            m_age = 0, cyc = 0;
  bit            m_pend[2] = '{0, 0};
  logic [RW-1:0] m_data[2] = '{0, 0};
  logic [1:0]    m_mode = 0;
  logic [DW-1:0] m_a = 0, m_b = 0;
  int            g_port[$];
  int            g_cyc[$];

  function automatic bit winner();
    if (req0_valid && req1_valid) return !m_last;
    return req1_valid;
  endfunction

  task automatic model_step();
    bit w;
    if (!hresetn) begin
      m_act = 0; m_pend[0] = 0; m_pend[1] = 0; m_data[0] = 0; m_data[1] = 0;
      m_mode = 0; m_a = 0; m_b = 0; m_last = 1; m_owner = 0;
    end else begin
      cyc++;
      if (m_pend[0] || m_pend[1]) begin
        if (m_owner ? rsp1_ready : rsp0_ready) m_pend[m_owner] = 0;
      end else if (m_act) begin
        m_age++;
        if (m_age == LAT) begin
          m_act = 0;
          m_pend[m_owner] = 1;
          m_data[m_owner] = clac_fn(m_mode, m_a, m_b);
        end
      end else if (req0_valid || req1_valid) begin
        w = winner();
        m_owner = w; m_last = w; m_act = 1; m_age = 0;
        m_mode = w ? req1_mode : req0_mode;
        m_a    = w ? req1_a : req0_a;
        m_b    = w ? req1_b : req0_b;
        g_port.push_back(int'(w));
        g_cyc.push_back(cyc);
      end
    end
  endtask

  initial forever begin
    @(posedge hclk or negedge hresetn);
    model_step();
  end

  initial forever begin
    bit idle, w;
    @(negedge hclk);
    idle = !m_act && !m_pend[0] && !m_pend[1];
    w = winner();
    chk("req0_ready", 64'(req0_ready), 64'(hresetn && idle && req0_valid && !w));
    chk("req1_ready", 64'(req1_ready), 64'(hresetn && idle && req1_valid && w));
    chk("ctrl", 64'(ctrl), 64'(m_act));
    chk("busy", 64'(busy), 64'(!idle));
    chk("rsp0_valid", 64'(rsp0_valid), 64'(m_pend[0]));
    chk("rsp1_valid", 64'(rsp1_valid), 64'(m_pend[1]));
    chk("rsp0_data", 64'(rsp0_data), 64'(m_data[0]));
    chk("rsp1_data", 64'(rsp1_data), 64'(m_data[1]));
    chk("operands", 64'({clac_mode, opcode_a, opcode_b}), 64'({m_mode, m_a, m_b}));
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  initial begin
    int n0, hc, hi, fnd;
    req0_valid = 0; req1_valid = 0; req0_mode = 0; req1_mode = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; rsp0_ready = 0; rsp1_ready = 0;
    q0_valid = 0; q0_a = 0; q0_b = 0; s0_ready = 0; result4 = 0;

    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
    hresetn = 1;

    // Single op: 3 + 4 on port 0
    tick();
    req0_valid = 1; req0_mode = 0; req0_a = 16'h0003; req0_b = 16'h0004; rsp0_ready = 1;
    @(negedge hclk) chk("single_ready", 64'(req0_ready), 64'd1);
    tick(); req0_valid = 0;
    @(negedge hclk) chk("single_ctrl", 64'(ctrl), 64'd1);
    @(negedge hclk);
    chk("single_ctrl_off", 64'(ctrl), 64'd0);
    chk("single_rsp", 64'({rsp0_valid, rsp1_valid}), 64'b10);
    chk("single_data", 64'(rsp0_data), 64'h7);
    repeat (3) tick();

    // Contention from reset
    hresetn = 0; tick();
    req0_valid = 1; req0_mode = 2; req0_a = 16'd5;  req0_b = 16'd6;
    req1_valid = 1; req1_mode = 1; req1_a = 16'd10; req1_b = 16'd3;
    rsp0_ready = 1; rsp1_ready = 1;
    n0 = g_port.size();
    hresetn = 1;
    repeat (14) tick();
    req0_valid = 0; req1_valid = 0;
    chk("cont_count", 64'(g_port.size() >= n0 + 5), 64'd1);
    if (g_port.size() >= n0 + 5)
      for (int k = 0; k < 4; k++) begin
        chk("cont_order", 64'(g_port[n0+k]), 64'(k % 2));
        chk("cont_gap", 64'(g_cyc[n0+k+1] - g_cyc[n0+k]), 64'd3);
      end
    repeat (4) tick();
    chk("cont_data0", 64'(rsp0_data), 64'h1e);
    chk("cont_data1", 64'(rsp1_data), 64'h7);

    // Backpressure on port 1 while port 0 waits
    rsp1_ready = 0; rsp0_ready = 1;
    req1_valid = 1; req1_mode = 3; req1_a = 16'h00ab; req1_b = 16'h00cd;
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_mode = 0; req0_a = 16'd1; req0_b = 16'd1;
    fnd = 0;
    for (int i = 0; i < 20 && fnd == 0; i++) begin
      @(negedge hclk);
      if (rsp1_valid) fnd = 1;
    end
    chk("bp_rsp_seen", 64'(fnd), 64'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge hclk);
      chk("bp_data", 64'(rsp1_data), 64'h00ab00cd);
      chk("bp_hold", 64'({rsp1_valid, busy, req0_ready}), 64'b110);
    end
    tick();
    rsp1_ready = 1;
    n0 = g_port.size();
    tick();
    hc = cyc;
    rsp1_ready = 0;
    tick();
    req0_valid = 0;
    chk("bp_resume", 64'(g_port.size()), 64'(n0 + 1));
    if (g_port.size() > n0) begin
      chk("bp_resume_port", 64'(g_port[n0]), 64'd0);
      chk("bp_resume_cyc", 64'(g_cyc[n0]), 64'(hc + 1));
    end
    repeat (4) tick();

    // Reset mid-EXEC
    req0_valid = 1; req0_mode = 0; req0_a = 16'd9; req0_b = 16'd9;
    tick();
    req0_valid = 0;
    chk("mid_exec_ctrl", 64'(ctrl), 64'd1);
    hresetn = 0;
    #1;
    chk("mid_rst_out", 64'({ctrl, busy, rsp0_valid, rsp1_valid}), 64'd0);
    tick();
    hresetn = 1;
    req0_valid = 1; req1_valid = 1;
    @(negedge hclk) chk("post_rst_tie", 64'({req0_ready, req1_ready}), 64'b10);
    tick();
    req0_valid = 0; req1_valid = 0;
    repeat (4) tick();

    // Lone requester on port 1
    rsp1_ready = 1; req1_valid = 1; req1_mode = 0; req1_a = 16'd2; req1_b = 16'd2;
    n0 = g_port.size();
    repeat (8) tick();
    req1_valid = 0;
    chk("lone_count", 64'(g_port.size()), 64'(n0 + 3));
    if (g_port.size() >= n0 + 3)
      for (int k = 0; k < 3; k++) begin
        chk("lone_port", 64'(g_port[n0+k]), 64'd1);
        if (k > 0) chk("lone_gap", 64'(g_cyc[n0+k] - g_cyc[n0+k-1]), 64'd3);
      end
    repeat (3) tick();

    // CLAC_LAT=4: only the value present in the last ctrl cycle is captured
    q0_valid = 1; q0_a = 16'd1; q0_b = 16'd2; result4 = 32'hdead0000;
    @(negedge hclk) chk("lat4_ready", 64'(q0_ready), 64'd1);
    tick();
    q0_valid = 0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge hclk);
      if (!ctrl4) break;
      hi++;
      result4 = (hi == 4) ? 32'h12345678 : 32'hdead0000 + 32'(hi);
    end
    chk("lat4_ctrl_cycles", 64'(hi), 64'd4);
    chk("lat4_rsp", 64'({s0_valid, s1_valid, busy4}), 64'b101);
    result4 = 32'hffffffff;
    tick();
    chk("lat4_data", 64'(s0_data), 64'h12345678);
    s0_ready = 1;
    tick();
    chk("lat4_done", 64'({s0_valid, busy4}), 64'd0);
    chk("lat4_keep", 64'(s0_data), 64'h12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clac_rr_sched.md
Name: clac_rr_sched

Overview:
- Round-robin scheduler that shares one combinational calculator (clac) between two requesters.
  - Port 0: the AHB slave interface.
  - Port 1: a local/secondary command source.
- Accepts one command at a time via valid/ready, drives ctrl/clac_mode/opcode_a/opcode_b for a programmable number of cycles, and captures result.
- Returns the result to the originating requester via a valid/ready response channel.
- Sits between requesters and the clac instance inside the calculator top level.

Parameters:
- CLAC_LAT, 1, cycles ctrl is held asserted before result is sampled (legal 1..15).
- DW, 16, operand width; result width is 2*DW.

Ports:
- hclk  input  1  clock; all logic rising-edge.
- hresetn  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 command valid.
- req0_ready  output  1  requester 0 command accepted this cycle when high with valid.
- req0_mode  input  2  requester 0 clac_mode.
- req0_a  input  DW  requester 0 operand A.
- req0_b  input  DW  requester 0 operand B.
- rsp0_valid  output  1  requester 0 result valid.
- rsp0_ready  input  1  requester 0 result taken.
- rsp0_data  output  2*DW  requester 0 result.
- req1_valid, req1_ready, req1_mode, req1_a, req1_b  same as requester 0, for requester 1.
- rsp1_valid, rsp1_ready, rsp1_data  same as requester 0, for requester 1.
- ctrl  output  1  clac enable.
- clac_mode  output  2  operation select to clac.
- opcode_a  output  DW  operand A to clac.
- opcode_b  output  DW  operand B to clac.
- result  input  2*DW  clac result.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (async, hresetn low): FSM=IDLE, last_grant=1 (so port 0 wins the first tie), lat_cnt=0.
  - Reset values: ctrl=0, clac_mode=0, opcode_a=0, opcode_b=0, rsp0/1_valid=0, rsp0/1_data=0, busy=0.
  - req0/1_ready=0 while hresetn low.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Combinational grant: only req0 valid -> port 0; only req1 valid -> port 1; both valid -> port != last_grant.
  - reqN_ready=1 only for the granted port, only in IDLE; the non-granted port sees ready=0.
  - On valid&ready: register mode/a/b into clac_mode/opcode_a/opcode_b, record owner, update last_grant=owner, set ctrl=1, lat_cnt=CLAC_LAT-1, go EXEC.
  - No valid: stay IDLE; ctrl=0; operand registers hold their last values.
- EXEC:
  - ctrl=1; operands stable.
  - lat_cnt decrements each cycle.
  - In the cycle lat_cnt==0: capture result into rspOWNER_data, deassert ctrl, assert rspOWNER_valid, go RESP.
  - With CLAC_LAT=1, result is captured on the edge after entering EXEC. Total accept-to-rsp_valid = CLAC_LAT+1 edges.
- RESP:
  - rspOWNER_valid held high, rspOWNER_data stable, until rspOWNER_ready=1.
  - On that edge: valid drops, go IDLE.
  - The other port's rsp_valid stays 0.
  - No new command is accepted in RESP (both req_ready=0).
  - Minimum issue interval is CLAC_LAT+2 cycles with rsp_ready tied high.
- rsp_ready asserted while rsp_valid=0 is ignored.
- reqN_valid may drop without acceptance; the scheduler has no obligation to that port.
- rspN_data retains its last value after rsp_valid drops, until overwritten by that port's next result.
- Fairness:
  - Under continuous contention, grants alternate 0,1,0,1.
  - A single active port is granted back-to-back regardless of last_grant.
- busy = (state != IDLE).
- Reset mid-EXEC or mid-RESP: immediate return to IDLE with all outputs at reset values; the in-flight result is discarded.

Test Plan:
- Single op: CLAC_LAT=1; req0 mode=0, a=16'h0003, b=16'h0004 -> req0_ready=1 at accept, ctrl high exactly 1 cycle, rsp0_valid 2 edges after accept with rsp0_data = clac result; rsp1_valid stays 0.
- Contention: req0_valid and req1_valid held high from reset, rsp ready tied 1 -> grant order 0,1,0,1; each accept is 3 cycles apart.
- Backpressure: rsp1_ready=0 for 5 cycles after rsp1_valid -> rsp1_valid and rsp1_data stable, busy=1, req0_ready=0 throughout; accept resumes the cycle after the rsp1_ready handshake.
- Latency param: CLAC_LAT=4 -> ctrl high 4 consecutive cycles, result sampled on the 4th; changing result before the last cycle has no effect on rsp_data.
- Reset mid-op: drop hresetn in EXEC -> ctrl=0, busy=0, rsp*_valid=0 asynchronously; after release, first tie grants port 0.
- Lone requester: only req1 active for 3 commands -> all 3 granted to port 1 back-to-back, with no idle gap beyond the RESP handshake.
